divider: RTL
============

DIVIDER -- requirements
Module: divider

Interface
REQ-001 The module SHALL have exactly these ports, in this order:
- `clk  input  1`: the single clock; all state updates on the rising edge.
- `reset  input  1`: synchronous, active-low reset; sampled only on the rising edge of `clk`.
- `start  input  1`: request; when high on an edge, begin a new division.
- `dvd  input  32`: signed two's-complement dividend.
- `dvs  input  32`: signed two's-complement divisor.
- `hi  output  32`: remainder.
- `lo  output  32`: quotient.
- `busy  output  1`: division in progress.
- `div0  output  1`: last accepted divisor was zero (only when `DIVIDER_ZERO_DETECT_EN` is defined).

Function
REQ-002 The block SHALL compute signed division with quotient truncated toward zero and remainder sign equal to the dividend sign (`dvd = lo*dvs + hi`).
REQ-003 It SHALL use a three-state FSM:
- IDLE: waiting.
- RUN: 32 shift/subtract iterations on magnitudes.
- FIX: one cycle of sign correction that writes `hi`/`lo`.
REQ-004 `dvd` and `dvs` SHALL be sampled only on the edge where `start` is high (edge E0).
- The operands SHALL be converted to magnitudes and loaded with the iteration counter set to 0.
- The FSM SHALL then enter RUN.
REQ-005 RUN SHALL perform one restoring iteration per edge, on E1..E32:
- Shift {remainder, quotient} left by 1.
- Trial-subtract the divisor magnitude in 33-bit width.
- If the difference is non-negative, keep it and set the quotient LSB to 1.
REQ-006 After E32 the FSM SHALL be in FIX.
- On E33 it SHALL write the sign-corrected results to `hi`/`lo` and return to IDLE.
REQ-007 `busy` SHALL be high from after E0 through E33 (33 cycles) and low from after E33; `hi`/`lo` are valid whenever `busy` is low after an accepted start.
REQ-008 `hi`/`lo` SHALL hold their previous values from E0 until E33; intermediate values are internal only.
REQ-009 `start` high while `busy` SHALL abort the current operation and restart at E0 with the new operands; no result is written for the aborted operation.
REQ-010 Dividend 0x80000000 with divisor 0xFFFFFFFF SHALL produce `lo`=0x80000000 (wrap) and `hi`=0.
REQ-011 Magnitude of 0x80000000 SHALL be handled as unsigned 0x80000000; there is no overflow flag.
REQ-012 When `start` is low and the FSM is in IDLE, all registers SHALL hold.

Reset
REQ-013 `reset` low on a rising edge SHALL force IDLE and set:
- `hi`=0, `lo`=0.
- `busy`=0, `div0`=0.
- Iteration counter = 0.
REQ-014 Reset SHALL override `start` on the same edge, and SHALL abort any operation in progress with no result written.
REQ-015 No output SHALL change asynchronously to `clk`.

Configuration
REQ-016 The macro `DIVIDER_ZERO_DETECT_EN` SHALL control divide-by-zero detection.
- Defined, `dvs`=0 at E0:
  - The FSM SHALL stay in IDLE and `busy` SHALL never assert.
  - `hi`/`lo` SHALL hold their previous values.
  - `div0` SHALL be 1 after E0.
  - `div0` SHALL clear on the next accepted start with nonzero `dvs`, or on reset.
- Not defined:
  - `div0` SHALL be constant 0.
  - `dvs`=0 SHALL run the full 33-cycle sequence.
  - The result SHALL be the raw algorithm output: magnitude quotient 0xFFFFFFFF and magnitude remainder |`dvd`|, then normal sign correction.

Verification
REQ-017 Reset sequence:
- Stimulus: `reset`=0 for 2 cycles, then 1.
- Response: `hi`=`lo`=0, `busy`=0, `div0`=0.
REQ-018 Positive divide:
- Stimulus: `dvd`=100, `dvs`=7, one-cycle `start`.
- Response: `busy` high for exactly 33 cycles; then `lo`=14, `hi`=2.
REQ-019 Mixed-sign divide:
- Stimulus: `dvd`=-7, `dvs`=2.
- Response: `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1).
- Stimulus: `dvd`=7, `dvs`=-2.
- Response: `lo`=-3, `hi`=1.
REQ-020 Overflow case:
- Stimulus: `dvd`=0x80000000, `dvs`=0xFFFFFFFF.
- Response: `lo`=0x80000000, `hi`=0.
REQ-021 Abort cases:
- Stimulus: restart with `dvd`=9, `dvs`=3 at cycle 10 of a 100/7 run.
- Response: `busy` extends 33 cycles from the restart, then `lo`=3, `hi`=0.
- Stimulus: `reset`=0 at cycle 20 of a run.
- Response: outputs return to 0 and the FSM is IDLE.
REQ-022 Divide by zero:
- Stimulus: `dvd`=7, `dvs`=0.
- With the macro: `busy` stays 0, `div0`=1, `hi`/`lo` unchanged.
- Without the macro: after 33 cycles `lo`=0xFFFFFFFF, `hi`=7, `div0`=0.

Source files
------------

// File: rtl/divider.sv
// Signed 32-bit restoring divider: quotient truncates toward zero, remainder takes the dividend's sign.
// Optional divide-by-zero detection is enabled by defining DIVIDER_ZERO_DETECT_EN.
module divider (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] dvd,
   input  logic [31:0] dvs,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        div0
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t      state_q, state_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_mag_q, dvs_mag_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        div0_q, div0_d;

   logic [32:0] shifted;
   logic [32:0] diff;
   logic        load;

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_mag_d = dvs_mag_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      div0_d    = div0_q;
      load      = 1'b0;

      shifted = {rem_q, quo_q[31]};
      diff    = shifted - {1'b0, dvs_mag_q};

      case (state_q)
         RUN: begin
            if (!diff[32]) begin
               rem_d = diff[31:0];
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = shifted[31:0];
               quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = FIX;
         end
         FIX: begin
            lo_d    = neg_quo_q ? -quo_q : quo_q;
            hi_d    = neg_rem_q ? -rem_q : rem_q;
            state_d = IDLE;
         end
         default: ;
      endcase

      // A start always wins over the current operation, aborting it without a write.
      if (start) begin
`ifdef DIVIDER_ZERO_DETECT_EN
         if (dvs == 32'd0) begin
            state_d = IDLE;
            div0_d  = 1'b1;
         end else begin
            div0_d = 1'b0;
            load   = 1'b1;
         end
`else
         load = 1'b1;
`endif
      end

      if (load) begin
         // Unsigned negation maps 0x80000000 to itself, which is its correct magnitude.
         rem_d     = 32'd0;
         quo_d     = dvd[31] ? -dvd : dvd;
         dvs_mag_d = dvs[31] ? -dvs : dvs;
         cnt_d     = 5'd0;
         neg_quo_d = dvd[31] ^ dvs[31];
         neg_rem_d = dvd[31];
         state_d   = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         rem_q     <= 32'd0;
         quo_q     <= 32'd0;
         dvs_mag_q <= 32'd0;
         cnt_q     <= 5'd0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         div0_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_mag_q <= dvs_mag_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         div0_q    <= div0_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q != IDLE);
`ifdef DIVIDER_ZERO_DETECT_EN
   assign div0 = div0_q;
`else
   assign div0 = 1'b0;
`endif

endmodule
